// File: rtl/game_level_fsm_pkg.sv
// ---------------------------------------------------------------------------
// game_level_fsm_pkg
// Definitions shared by the game-progress controller and the VGA top level:
// the one-hot game state encodings, the field widths of the level/kill
// outputs, and small decode helpers that turn a game state into the level
// number and zombie spawn enable.
// ---------------------------------------------------------------------------
package game_level_fsm_pkg;

    localparam int STATE_W = 8;
    localparam int LEVEL_W = 2;
    localparam int KILL_W  = 8;
    localparam int TOTAL_W = 16;

    // One-hot game states. The VGA top picks its screen straight from these bits.
    typedef enum logic [STATE_W-1:0] {
        ST_I     = 8'h80,
        ST_L1    = 8'h40,
        ST_NL2   = 8'h20,
        ST_L2    = 8'h10,
        ST_NL3   = 8'h08,
        ST_L3    = 8'h04,
        ST_DONEL = 8'h02,
        ST_DONEW = 8'h01
    } gameState_t;

    // Level shown to the player: an intermission already reports the level it leads into.
    function automatic logic [LEVEL_W-1:0] levelOf(input gameState_t s);
        logic [LEVEL_W-1:0] lvl;
        lvl = '0;
        case (s)
            ST_L1:          lvl = 2'd1;
            ST_NL2, ST_L2:  lvl = 2'd2;
            ST_NL3, ST_L3:  lvl = 2'd3;
            default:        lvl = 2'd0;
        endcase
        return lvl;
    endfunction

    // Zombies only spawn while a level is actually being played.
    function automatic logic spawnOf(input gameState_t s);
        return (s == ST_L1) || (s == ST_L2) || (s == ST_L3);
    endfunction

endpackage

// File: rtl/game_level_fsm_level_timer.sv
// ---------------------------------------------------------------------------
// level_timer
// Intermission timer: a TMR_W-bit up-counter with synchronous clear and
// count enable, flagging its terminal count at NL_HOLD-1.
// Ports:
//   i_clk       system clock
//   i_reset_n   synchronous reset, active-low
//   i_clear     return the count to zero (wins over i_enable)
//   i_enable    advance the count by one
//   o_terminal  high while the count equals NL_HOLD-1
// ---------------------------------------------------------------------------
module level_timer #(
    parameter int NL_HOLD = 200_000_000,
    parameter int TMR_W   = 28
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(NL_HOLD - 1);

    logic [TMR_W-1:0] r_count;

    // The count only ever runs inside an intermission; the controller clears it
    // everywhere else, so each intermission starts its wait from zero.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TMR_W'(1);
        end
    end

    // Terminal flag is a plain compare so the controller can leave on this very cycle.
    assign o_terminal = (r_count == HOLD_LAST);

endmodule

// File: rtl/game_level_fsm.sv
// ---------------------------------------------------------------------------
// game_level_fsm
// Game-progress controller ahead of the VGA top level. Walks the player from
// idle through three levels with timed intermissions, ending on a lose or win
// screen, and keeps the per-level and total kill counts.
// Ports:
//   i_clk              system clock (100 MHz)
//   i_reset_n          synchronous reset, active-low
//   i_select_pulse     one-cycle debounced select (start / skip / restart)
//   i_zombie_killed    one-cycle pulse per zombie destroyed
//   i_zombie_breach    one-cycle pulse when a zombie reaches the house
//   o_state            one-hot game state
//   o_level            0 = idle/done, else current or upcoming level
//   o_spawn_en         zombie generator enable, high only in L1..L3
//   o_level_kills      kills in the current level, saturating at 8'hFF
//   o_zombies_killed   kills since the last start, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module game_level_fsm
    import game_level_fsm_pkg::*;
#(
    parameter int KILLS_L1 = 5,
    parameter int KILLS_L2 = 10,
    parameter int KILLS_L3 = 15,
    parameter int NL_HOLD  = 200_000_000,
    parameter int TMR_W    = 28
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_select_pulse,
    input  logic               i_zombie_killed,
    input  logic               i_zombie_breach,
    output logic [STATE_W-1:0] o_state,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_spawn_en,
    output logic [KILL_W-1:0]  o_level_kills,
    output logic [TOTAL_W-1:0] o_zombies_killed
);

    localparam logic [KILL_W-1:0] GOAL_L1 = KILL_W'(KILLS_L1);
    localparam logic [KILL_W-1:0] GOAL_L2 = KILL_W'(KILLS_L2);
    localparam logic [KILL_W-1:0] GOAL_L3 = KILL_W'(KILLS_L3);

    logic [STATE_W-1:0] r_state;
    logic [LEVEL_W-1:0] r_level;
    logic               r_spawnEn;
    logic [KILL_W-1:0]  r_levelKills;
    logic [TOTAL_W-1:0] r_zombiesKilled;

    gameState_t         w_nextState;
    logic [LEVEL_W-1:0] w_level;
    logic               w_spawnEn;
    logic               w_countKill;
    logic               w_clearAll;
    logic               w_nlExit;
    logic               w_inNl;
    logic               w_timerDone;
    logic [KILL_W-1:0]  w_levelKillsInc;
    logic [TOTAL_W-1:0] w_zombiesKilledInc;

    // Saturating increments: both counters hold at all-ones instead of wrapping.
    assign w_levelKillsInc    = (r_levelKills == '1) ? r_levelKills : r_levelKills + KILL_W'(1);
    assign w_zombiesKilledInc = (r_zombiesKilled == '1) ? r_zombiesKilled : r_zombiesKilled + TOTAL_W'(1);

    // The intermission timer runs only in NL2/NL3 and is held at zero otherwise,
    // and is also cleared on the exit edge so the next intermission starts fresh.
    level_timer #(
        .NL_HOLD (NL_HOLD),
        .TMR_W   (TMR_W)
    ) u_levelTimer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clear    (!w_inNl || w_nlExit),
        .i_enable   (w_inNl),
        .o_terminal (w_timerDone)
    );

    // State register. Level and spawn enable are decoded from the next state and
    // registered on the same edge so they never lag the state by a cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= ST_I;
            r_level   <= '0;
            r_spawnEn <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_level   <= w_level;
            r_spawnEn <= w_spawnEn;
        end
    end

    // Next-state logic. Breach beats kill in a level; a kill that reaches the
    // level goal moves on in the same edge that counts it. Anything that is
    // not one of the eight one-hot codes (upset, X) falls back to idle.
    always_comb begin
        w_nextState = gameState_t'(r_state);
        w_countKill = 1'b0;
        w_clearAll  = 1'b0;
        w_nlExit    = 1'b0;
        w_inNl      = 1'b0;
        case (r_state)
            ST_I: begin
                if (i_select_pulse) begin
                    w_nextState = ST_L1;
                    w_clearAll  = 1'b1;
                end
            end
            ST_L1: begin
                if (i_zombie_breach) begin
                    w_nextState = ST_DONEL;
                end else if (i_zombie_killed) begin
                    w_countKill = 1'b1;
                    if (w_levelKillsInc == GOAL_L1) begin
                        w_nextState = ST_NL2;
                    end
                end
            end
            ST_L2: begin
                if (i_zombie_breach) begin
                    w_nextState = ST_DONEL;
                end else if (i_zombie_killed) begin
                    w_countKill = 1'b1;
                    if (w_levelKillsInc == GOAL_L2) begin
                        w_nextState = ST_NL3;
                    end
                end
            end
            ST_L3: begin
                if (i_zombie_breach) begin
                    w_nextState = ST_DONEL;
                end else if (i_zombie_killed) begin
                    w_countKill = 1'b1;
                    if (w_levelKillsInc == GOAL_L3) begin
                        w_nextState = ST_DONEW;
                    end
                end
            end
            ST_NL2: begin
                w_inNl = 1'b1;
                if (i_select_pulse || w_timerDone) begin
                    w_nextState = ST_L2;
                    w_nlExit    = 1'b1;
                end
            end
            ST_NL3: begin
                w_inNl = 1'b1;
                if (i_select_pulse || w_timerDone) begin
                    w_nextState = ST_L3;
                    w_nlExit    = 1'b1;
                end
            end
            ST_DONEL, ST_DONEW: begin
                if (i_select_pulse) begin
                    w_nextState = ST_I;
                end
            end
            default: begin
                w_nextState = ST_I;
            end
        endcase
    end

    // Output decode, taken from the next state so the registered copies line up with it.
    always_comb begin
        w_level   = levelOf(w_nextState);
        w_spawnEn = spawnOf(w_nextState);
    end

    // Kill counters. A new game clears both; leaving an intermission clears only
    // the per-level count so the running total survives into the next level.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_levelKills    <= '0;
            r_zombiesKilled <= '0;
        end else if (w_clearAll) begin
            r_levelKills    <= '0;
            r_zombiesKilled <= '0;
        end else if (w_countKill) begin
            r_levelKills    <= w_levelKillsInc;
            r_zombiesKilled <= w_zombiesKilledInc;
        end else if (w_nlExit) begin
            r_levelKills    <= '0;
        end
    end

    assign o_state          = r_state;
    assign o_level          = r_level;
    assign o_spawn_en       = r_spawnEn;
    assign o_level_kills    = r_levelKills;
    assign o_zombies_killed = r_zombiesKilled;

endmodule

// File: tb/tb_game_level_fsm.sv
// ---------------------------------------------------------------------------
// tb_game_level_fsm
// Self-checking bench for game_level_fsm with short levels and a 16-cycle
// intermission. A reference model tracks the game as phase / level / counts
// and every output is compared against it after each clock edge.
// ---------------------------------------------------------------------------
module tb_game_level_fsm;

    localparam int NL_HOLD  = 16;
    localparam int KILLS_L1 = 2;
    localparam int KILLS_L2 = 3;
    localparam int KILLS_L3 = 4;

    localparam int P_IDLE  = 0;
    localparam int P_PLAY  = 1;
    localparam int P_INTER = 2;
    localparam int P_LOST  = 3;
    localparam int P_WON   = 4;

    logic        clk;
    logic        resetN;
    logic        selectPulse;
    logic        zombieKilled;
    logic        zombieBreach;
    logic [7:0]  state;
    logic [1:0]  level;
    logic        spawnEn;
    logic [7:0]  levelKills;
    logic [15:0] zombiesKilled;

    int checkCount;
    int passCount;

    int mPhase;
    int mLevel;
    int mLvlKills;
    int mTotal;
    int mTimer;

    game_level_fsm #(
        .KILLS_L1 (KILLS_L1),
        .KILLS_L2 (KILLS_L2),
        .KILLS_L3 (KILLS_L3),
        .NL_HOLD  (NL_HOLD),
        .TMR_W    (28)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (resetN),
        .i_select_pulse   (selectPulse),
        .i_zombie_killed  (zombieKilled),
        .i_zombie_breach  (zombieBreach),
        .o_state          (state),
        .o_level          (level),
        .o_spawn_en       (spawnEn),
        .o_level_kills    (levelKills),
        .o_zombies_killed (zombiesKilled)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Kills required to clear a given level
    function automatic int needFor(input int lvl);
        return (lvl == 1) ? KILLS_L1 : (lvl == 2) ? KILLS_L2 : KILLS_L3;
    endfunction

    // Screen code the top level should see for the model's phase and level
    function automatic logic [7:0] expState();
        logic [7:0] s;
        s = 8'h80;
        case (mPhase)
            P_PLAY:  s = (mLevel == 1) ? 8'h40 : (mLevel == 2) ? 8'h10 : 8'h04;
            P_INTER: s = (mLevel == 2) ? 8'h20 : 8'h08;
            P_LOST:  s = 8'h02;
            P_WON:   s = 8'h01;
            default: s = 8'h80;
        endcase
        return s;
    endfunction

    // One clock of the game rules, applied to the model
    task automatic modelStep(input logic rstn, input logic sel, input logic kill, input logic brk);
        if (!rstn) begin
            mPhase = P_IDLE; mLevel = 0; mLvlKills = 0; mTotal = 0; mTimer = 0;
        end else begin
            case (mPhase)
                P_IDLE: if (sel) begin
                    mPhase = P_PLAY; mLevel = 1; mLvlKills = 0; mTotal = 0;
                end
                P_PLAY: begin
                    if (brk) begin
                        mPhase = P_LOST;
                    end else if (kill) begin
                        if (mLvlKills < 255) mLvlKills++;
                        if (mTotal < 65535) mTotal++;
                        if (mLvlKills == needFor(mLevel)) begin
                            if (mLevel < 3) begin
                                mPhase = P_INTER; mLevel++; mTimer = 0;
                            end else begin
                                mPhase = P_WON;
                            end
                        end
                    end
                end
                P_INTER: begin
                    if (sel || mTimer == NL_HOLD - 1) begin
                        mPhase = P_PLAY; mLvlKills = 0; mTimer = 0;
                    end else begin
                        mTimer++;
                    end
                end
                default: if (sel) mPhase = P_IDLE;
            endcase
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then drop the pulses
    task automatic applyStimulus(input logic rstn, input logic sel, input logic kill, input logic brk);
        @(negedge clk);
        resetN = rstn; selectPulse = sel; zombieKilled = kill; zombieBreach = brk;
        @(posedge clk);
        modelStep(rstn, sel, kill, brk);
        #1;
        resetN = 1'b1; selectPulse = 1'b0; zombieKilled = 1'b0; zombieBreach = 1'b0;
    endtask

    task automatic checkOne(input string tag, input string name, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s/%s observed %0h expected %0h", tag, name, observed, expected);
    endtask

    // Compare every output against the model
    task automatic checkOutput(input string tag);
        checkOne(tag, "state",  {8'h00, state}, {8'h00, expState()});
        checkOne(tag, "level",  {14'h0, level},
                 {14'h0, ((mPhase == P_PLAY || mPhase == P_INTER) ? 2'(mLevel) : 2'd0)});
        checkOne(tag, "spawn",  {15'h0, spawnEn}, {15'h0, (mPhase == P_PLAY)});
        checkOne(tag, "lkills", {8'h00, levelKills}, 16'(mLvlKills));
        checkOne(tag, "total",  zombiesKilled, 16'(mTotal));
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput(tag);
        end
    endtask

    task automatic killTimes(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput(tag);
        end
    endtask

    // Directed scenarios followed by a randomized soak
    initial begin
        logic rr, ss, kk, bb;
        checkCount = 0; passCount = 0;
        resetN = 1'b1; selectPulse = 1'b0; zombieKilled = 1'b0; zombieBreach = 1'b0;
        mPhase = P_IDLE; mLevel = 0; mLvlKills = 0; mTotal = 0; mTimer = 0;

        $display("[TB] reset and start");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset");
        checkOne("reset", "idleCode", {8'h00, state}, 16'h0080);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("start");
        checkOne("start", "l1Code", {8'h00, state}, 16'h0040);

        $display("[TB] level 1 clear and intermission timeout");
        killTimes(2, "l1kill");
        checkOne("l1kill", "nl2Code", {8'h00, state}, 16'h0020);
        runCycles(15, "nl2wait");
        checkOne("nl2wait", "stillNl2", {8'h00, state}, 16'h0020);
        runCycles(1, "nl2exit");
        checkOne("nl2exit", "l2Code", {8'h00, state}, 16'h0010);

        $display("[TB] full run to win");
        killTimes(3, "l2kill");
        runCycles(16, "nl3wait");
        killTimes(4, "l3kill");
        checkOne("win", "wonCode", {8'h00, state}, 16'h0001);
        checkOne("win", "total9", zombiesKilled, 16'd9);
        killTimes(2, "winFrozen");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("winRestart");

        $display("[TB] breach beats kill");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("start2");
        killTimes(2, "l1kill2");
        runCycles(16, "nl2wait2");
        killTimes(1, "l2kill2");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("breach");
        checkOne("breach", "lostCode", {8'h00, state}, 16'h0002);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("lostRestart");

        $display("[TB] intermission skip and straggler kill");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        killTimes(2, "l1kill3");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("skipNl2");
        killTimes(3, "l2kill3");
        killTimes(1, "nl3straggler");
        runCycles(2, "nl3hold");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("skipNl3");
        checkOne("skipNl3", "l3Code", {8'h00, state}, 16'h0004);

        $display("[TB] reset mid-level and illegal state recovery");
        killTimes(1, "l3kill4");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("midReset");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        killTimes(1, "preForce");
        @(negedge clk);
        force dut.r_state = 8'h00;
        #1;
        release dut.r_state;
        @(posedge clk);
        mPhase = P_IDLE; mLevel = 0; mTimer = 0;
        #1;
        checkOutput("illegal");

        $display("[TB] randomized play");
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(199) != 0);
            ss = ($urandom_range(9) == 0);
            kk = ($urandom_range(1) == 0);
            bb = ($urandom_range(49) == 0);
            applyStimulus(rr, ss, kk, bb);
            checkOutput("random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
